// File: rtl/ext_mem_pkg.sv
// Shared types and widths for the external-memory BRAM controller.
package ext_mem_pkg;
    localparam int EXT_ADDR_W = 32;
    localparam int EXT_DATA_W = 32;
    localparam int EXT_MASK_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_MEM,
        RD_RESP
    } state_t;

    // Encoding of the last_grant arbitration bit
    localparam logic GRANT_W = 1'b0;
    localparam logic GRANT_R = 1'b1;
endpackage

// File: rtl/bram_sp_bytewe.sv
// Single-port block RAM with per-byte write enables and a registered read port.
module bram_sp_bytewe
    import ext_mem_pkg::*;
#(
    parameter int    ADDR_W    = 14,
    parameter string INIT_FILE = ""
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic [EXT_MASK_W-1:0] we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [EXT_DATA_W-1:0] wdata,
    output logic [EXT_DATA_W-1:0] rdata
);
    logic [EXT_DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (en) begin
            for (int i = 0; i < EXT_MASK_W; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/ext_mem_bram_ctrl.sv
// Terminates the core's split-channel memory port on an on-chip BRAM,
// serving one write or read transaction at a time.
module ext_mem_bram_ctrl
    import ext_mem_pkg::*;
#(
    parameter int    MEM_ADDR_WIDTH = 14,
    parameter string INIT_FILE      = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  waen,
    input  logic [EXT_ADDR_W-1:0] waddr,
    output logic                  wardy,
    input  logic                  wden,
    input  logic [EXT_DATA_W-1:0] wdata,
    input  logic [EXT_MASK_W-1:0] wmask,
    output logic                  wdrdy,
    output logic                  wbvld,
    input  logic                  raen,
    input  logic [EXT_ADDR_W-1:0] raddr,
    output logic                  rardy,
    input  logic                  rden,
    output logic [EXT_DATA_W-1:0] rdata,
    output logic                  rdrdy
);
    state_t                    state, state_nxt;
    logic                      last_grant;
    logic                      grant_w, grant_r;
    logic [MEM_ADDR_WIDTH-1:0] idx;
    logic                      bram_en;
    logic [EXT_MASK_W-1:0]     bram_we;
    logic [EXT_DATA_W-1:0]     bram_q;
    logic                      unused_addr_bits;

    // Byte offset and bits above the array alias silently
    assign unused_addr_bits = ^{waddr[1:0], waddr[EXT_ADDR_W-1:MEM_ADDR_WIDTH+2],
                                raddr[1:0], raddr[EXT_ADDR_W-1:MEM_ADDR_WIDTH+2]};

    assign grant_w = waen && (!raen || last_grant == GRANT_R);
    assign grant_r = raen && (!waen || last_grant == GRANT_W);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset)                                      last_grant <= GRANT_R;
        else if (state == IDLE && (grant_w || grant_r)) last_grant <= ~last_grant;
    end

    always_ff @(posedge clock) begin
        if (state == IDLE) begin
            if (grant_w)      idx <= waddr[MEM_ADDR_WIDTH+1:2];
            else if (grant_r) idx <= raddr[MEM_ADDR_WIDTH+1:2];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_w)      state_nxt = WR_DATA;
                else if (grant_r) state_nxt = RD_MEM;
            end
            WR_DATA: if (wden) state_nxt = WR_RESP;
            WR_RESP: state_nxt = IDLE;
            RD_MEM:  state_nxt = RD_RESP;
            RD_RESP: if (rden) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wardy = 1'b0;
        rardy = 1'b0;
        wdrdy = 1'b0;
        wbvld = 1'b0;
        rdrdy = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    wardy = grant_w;
                    rardy = grant_r;
                end
                WR_DATA: wdrdy = 1'b1;
                WR_RESP: wbvld = 1'b1;
                RD_RESP: rdrdy = 1'b1;
                default: ;
            endcase
        end
    end

    // A write is gated by wdrdy, so a reset cycle never commits data
    assign bram_we = (wdrdy && wden) ? wmask : '0;
    assign bram_en = (wdrdy && wden) || (state == RD_MEM && !reset);
    assign rdata   = rdrdy ? bram_q : '0;

    bram_sp_bytewe #(
        .ADDR_W    (MEM_ADDR_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_bram (
        .clock (clock),
        .en    (bram_en),
        .we    (bram_we),
        .addr  (idx),
        .wdata (wdata),
        .rdata (bram_q)
    );
endmodule

// File: tb/tb_ext_mem_bram_ctrl.sv
// Directed self-checking bench for ext_mem_bram_ctrl.
module tb_ext_mem_bram_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        waen, wden, raen, rden;
    logic [31:0] waddr, wdata, raddr;
    logic [3:0]  wmask;
    logic        wardy, wdrdy, wbvld, rardy, rdrdy;
    logic [31:0] rdata;
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    ext_mem_bram_ctrl #(.MEM_ADDR_WIDTH(14), .INIT_FILE("")) dut (
        .clock(clock), .reset(reset),
        .waen(waen), .waddr(waddr), .wardy(wardy),
        .wden(wden), .wdata(wdata), .wmask(wmask), .wdrdy(wdrdy), .wbvld(wbvld),
        .raen(raen), .raddr(raddr), .rardy(rardy),
        .rden(rden), .rdata(rdata), .rdrdy(rdrdy)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered in an IDLE cycle; returns in the following IDLE cycle
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input string tag);
        waen = 1'b1; waddr = a; wden = 1'b1; wdata = d; wmask = m;
        #1;
        chk1({tag, "_wardy"}, wardy, 1'b1);
        tick();
        waen = 1'b0; waddr = ~a;
        #1;
        chk1({tag, "_wdrdy"}, wdrdy, 1'b1);
        chk1({tag, "_wbvld_early"}, wbvld, 1'b0);
        tick();
        wden = 1'b0;
        #1;
        chk1({tag, "_wbvld"}, wbvld, 1'b1);
        tick();
        #1;
        chk1({tag, "_wbvld_once"}, wbvld, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        raen = 1'b1; raddr = a; rden = 1'b1;
        #1;
        chk1({tag, "_rardy"}, rardy, 1'b1);
        tick();
        raen = 1'b0; raddr = ~a;
        #1;
        chk1({tag, "_rdrdy_early"}, rdrdy, 1'b0);
        tick();
        #1;
        chk1({tag, "_rdrdy"}, rdrdy, 1'b1);
        chk32({tag, "_rdata"}, rdata, exp);
        tick();
        #1;
        chk1({tag, "_rdrdy_idle"}, rdrdy, 1'b0);
        rden = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        waen = 1'b1; wden = 1'b1; raen = 1'b1; rden = 1'b1;
        waddr = 32'h0; raddr = 32'h0; wdata = 32'hFFFF_FFFF; wmask = 4'hF;
        tick();
        tick();
        #1;
        chk1("rst_wardy", wardy, 1'b0);
        chk1("rst_rardy", rardy, 1'b0);
        chk1("rst_wdrdy", wdrdy, 1'b0);
        chk1("rst_wbvld", wbvld, 1'b0);
        chk1("rst_rdrdy", rdrdy, 1'b0);
        chk32("rst_rdata", rdata, 32'h0);
        reset = 1'b0;
        waen = 1'b0; wden = 1'b0; raen = 1'b0; rden = 1'b0;
        tick();

        wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, "wr10");
        rd(32'h0000_0010, 32'hDEAD_BEEF, "rd10");

        wr(32'h0000_0020, 32'h1122_3344, 4'hF, "wr20");
        wr(32'h0000_0020, 32'h0000_AA00, 4'h2, "wr20_m2");
        rd(32'h0000_0020, 32'h1122_AA44, "rd20_m2");
        wr(32'h0000_0020, 32'hFFFF_FFFF, 4'h0, "wr20_m0");
        rd(32'h0000_0020, 32'h1122_AA44, "rd20_m0");
        wr(32'h0000_0024, 32'hA1B2_C3D4, 4'hF, "wr24");
        wr(32'h0000_0024, 32'h5566_7788, 4'h5, "wr24_m5");
        rd(32'h0000_0024, 32'hA166_C388, "rd24_m5");

        wr(32'h0001_0004, 32'hCAFE_F00D, 4'hF, "wr_alias");
        rd(32'h0000_0004, 32'hCAFE_F00D, "rd_alias");
        rd(32'h0000_0007, 32'hCAFE_F00D, "rd_lowbits");

        // Read stalled in RD_RESP by rden low, with both address channels requesting
        raen = 1'b1; raddr = 32'h0000_0010; rden = 1'b0;
        #1;
        chk1("stall_rardy", rardy, 1'b1);
        tick();
        waen = 1'b1; waddr = 32'h0000_0030;
        #1;
        chk1("stall_rdmem_wardy", wardy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            chk1("stall_rdrdy", rdrdy, 1'b1);
            chk32("stall_rdata", rdata, 32'hDEAD_BEEF);
            chk1("stall_rardy_hold", rardy, 1'b0);
            chk1("stall_wardy_hold", wardy, 1'b0);
        end
        rden = 1'b1; waen = 1'b0; raen = 1'b0;
        tick();
        #1;
        chk1("stall_release_rdrdy", rdrdy, 1'b0);
        rden = 1'b0;

        // Fresh reset so arbitration starts with write priority
        reset = 1'b1;
        tick();
        reset = 1'b0;
        waen = 1'b1; raen = 1'b1; wden = 1'b1; rden = 1'b1;
        waddr = 32'h0000_0040; raddr = 32'h0000_0040; wmask = 4'hF;
        for (int p = 0; p < 2; p++) begin
            wdata = (p == 0) ? 32'h1357_9BDF : 32'h2468_ACE0;
            #1;
            chk1("arb_w_wardy", wardy, 1'b1);
            chk1("arb_w_rardy", rardy, 1'b0);
            tick();
            tick();
            #1;
            chk1("arb_wbvld", wbvld, 1'b1);
            chk1("arb_w_rdrdy", rdrdy, 1'b0);
            tick();
            #1;
            chk1("arb_r_rardy", rardy, 1'b1);
            chk1("arb_r_wardy", wardy, 1'b0);
            tick();
            tick();
            #1;
            chk1("arb_rdrdy", rdrdy, 1'b1);
            chk1("arb_r_wbvld", wbvld, 1'b0);
            chk32("arb_rdata", rdata, (p == 0) ? 32'h1357_9BDF : 32'h2468_ACE0);
            tick();
        end
        waen = 1'b0; raen = 1'b0; wden = 1'b0; rden = 1'b0;
        tick();

        // Reset while waiting for write data: nothing committed
        waen = 1'b1; waddr = 32'h0000_0010; wdata = 32'h0BAD_0BAD; wmask = 4'hF;
        #1;
        chk1("rstw_wardy", wardy, 1'b1);
        tick();
        waen = 1'b0;
        #1;
        chk1("rstw_wdrdy", wdrdy, 1'b1);
        reset = 1'b1; wden = 1'b1;
        #1;
        chk1("rstw_wdrdy_forced", wdrdy, 1'b0);
        tick();
        reset = 1'b0; wden = 1'b0;
        #1;
        chk1("rstw_no_wbvld0", wbvld, 1'b0);
        tick();
        #1;
        chk1("rstw_no_wbvld1", wbvld, 1'b0);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "rstw_rd");

        // Reset while a read response is pending
        raen = 1'b1; raddr = 32'h0000_0020; rden = 1'b0;
        tick();
        raen = 1'b0;
        tick();
        #1;
        chk1("rstr_rdrdy", rdrdy, 1'b1);
        chk32("rstr_rdata", rdata, 32'h1122_AA44);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk1("rstr_rdrdy_drop", rdrdy, 1'b0);
        tick();
        #1;
        chk1("rstr_rdrdy_idle", rdrdy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
